// File: rtl/fetch_unit_pkg.sv
// Shared constants and encodings for the IF-stage fetch unit.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // What the IF/ID register loads at the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_MEM    = 2'd2,
        IFID_SKID   = 2'd3
    } ifid_sel_e;

    function automatic logic is_busy(input fetch_state_e s);
        return (s == ST_WAIT) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register for a response that arrives while decode is stalled.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clr_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Clear wins over load so a flush always empties the entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, single-outstanding imem handshake, skid buffer and IF/ID register.
// Applies hazard-unit stalls (PCWrite/IFIDWrite) and redirects (Flush).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               Flush,
    input  logic [XLEN-1:0]    pc_target,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [XLEN-1:0]    IFID_PC,
    output logic [XLEN-1:0]    IFID_PC4,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic               IFID_Valid,
    output logic               fetch_busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    fetch_state_e state_q, state_d;
    ifid_sel_e    ifid_sel;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    pc_plus4, pc_seq, tgt_aligned;
    logic               ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0]    ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0]    ifid_pc4_q, ifid_pc4_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;

    logic               skid_load, skid_clr, skid_valid;
    logic [XLEN-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign pc_plus4    = pc_q + PC_STEP;
    assign pc_seq      = PCWrite ? pc_plus4 : pc_q;
    assign tgt_aligned = pc_target & ALIGN_MASK;

    fetch_skid_buffer #(
        .XLEN(XLEN)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (!Flush) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (Flush) begin
                    state_d = imem_valid ? ST_WAIT : ST_DRAIN;
                end else if (imem_valid) begin
                    if (!IFIDWrite)     state_d = ST_FULL;
                    else if (!PCWrite)  state_d = ST_FETCH;
                end
            end
            ST_FULL: begin
                if (Flush)           state_d = ST_FETCH;
                else if (IFIDWrite)  state_d = ST_WAIT;
            end
            ST_DRAIN: begin
                if (imem_valid) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Request, PC and IF/ID/skid controls; Flush overrides every load and stall.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        pc_d      = pc_q;
        ifid_sel  = IFID_HOLD;
        skid_load = 1'b0;
        skid_clr  = 1'b0;

        if (Flush) begin
            pc_d     = tgt_aligned;
            skid_clr = 1'b1;
            ifid_sel = IFID_BUBBLE;
        end

        case (state_q)
            ST_FETCH: begin
                if (!Flush) begin
                    imem_req = 1'b1;
                    if (IFIDWrite) ifid_sel = IFID_BUBBLE;
                end
            end
            ST_WAIT: begin
                if (Flush) begin
                    if (imem_valid) begin
                        imem_req  = 1'b1;
                        imem_addr = tgt_aligned;
                    end
                end else if (imem_valid && IFIDWrite) begin
                    ifid_sel = IFID_MEM;
                    if (PCWrite) begin
                        pc_d      = pc_plus4;
                        imem_req  = 1'b1;
                        imem_addr = pc_plus4;
                    end
                end else if (imem_valid) begin
                    skid_load = 1'b1;
                end else if (IFIDWrite) begin
                    ifid_sel = IFID_BUBBLE;
                end
            end
            ST_FULL: begin
                if (!Flush && IFIDWrite && skid_valid) begin
                    ifid_sel  = IFID_SKID;
                    skid_clr  = 1'b1;
                    pc_d      = pc_seq;
                    imem_req  = 1'b1;
                    imem_addr = pc_seq;
                end
            end
            ST_DRAIN: begin
                if (!Flush && IFIDWrite) ifid_sel = IFID_BUBBLE;
            end
            default: ;
        endcase

        if (!rst_n) imem_req = 1'b0;
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        case (ifid_sel)
            IFID_BUBBLE: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
            IFID_MEM: begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = imem_rdata;
            end
            IFID_SKID: begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc;
                ifid_pc4_d   = skid_pc + PC_STEP;
                ifid_instr_d = skid_instr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC & ALIGN_MASK;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= PC_STEP;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign IFID_PC    = ifid_pc_q;
    assign IFID_PC4   = ifid_pc4_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_Valid = ifid_valid_q;
    assign fetch_busy = is_busy(state_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, latency-3 flush sequence, random run vs queue model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst_n, PCWrite, IFIDWrite, Flush;
    logic [31:0] pc_target, imem_addr, imem_rdata, IFID_PC, IFID_PC4, IFID_Instr;
    logic        imem_req, imem_valid, IFID_Valid, fetch_busy;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .Flush      (Flush),
        .pc_target  (pc_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .IFID_PC    (IFID_PC),
        .IFID_PC4   (IFID_PC4),
        .IFID_Instr (IFID_Instr),
        .IFID_Valid (IFID_Valid),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Directed vector table: inputs of one cycle and the outputs expected in that cycle.
    typedef struct {
        logic        rst, pcw, ifw, fl;
        logic [31:0] tgt;
        logic        mv;
        logic [31:0] md;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc, e_ins;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input int rst, input int pcw, input int ifw, input int fl,
                                 input logic [31:0] tgt, input int mv, input logic [31:0] md,
                                 input int e_req, input logic [31:0] e_addr, input int e_val,
                                 input logic [31:0] e_pc, input logic [31:0] e_ins, input int e_busy);
        vec_t r;
        r.rst = (rst != 0);  r.pcw = (pcw != 0);  r.ifw = (ifw != 0);  r.fl = (fl != 0);
        r.tgt = tgt;         r.mv = (mv != 0);    r.md = md;
        r.e_req = (e_req != 0);  r.e_addr = e_addr;  r.e_val = (e_val != 0);
        r.e_pc = e_pc;       r.e_ins = e_ins;     r.e_busy = (e_busy != 0);
        return r;
    endfunction

    // Reference model: outstanding request and skid kept as queues, IF/ID as plain fields.
    typedef struct { logic [31:0] addr; bit live; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } skid_t;
    typedef struct { int due; logic [31:0] addr; } mreq_t;

    pend_t       pend_q[$];
    skid_t       skid_q[$];
    mreq_t       mem_q[$];
    logic [31:0] m_pc, m_pc_ifid, m_ins_ifid;
    bit          m_val_ifid;
    int          cyc, n_req;
    logic [31:0] last_req_addr;

    task automatic model_reset();
        pend_q.delete();
        skid_q.delete();
        mem_q.delete();
        m_pc = 32'h0;
        m_val_ifid = 1'b0;
        m_pc_ifid = 32'h0;
        m_ins_ifid = NOP;
    endtask

    task automatic model_bubble();
        m_val_ifid = 1'b0;
        m_ins_ifid = NOP;
    endtask

    task automatic model_issue(input logic [31:0] a, output bit req, output logic [31:0] addr);
        req = 1'b1;
        addr = a;
        pend_q.push_back('{a, 1'b1});
    endtask

    task automatic model_step(input bit pcw, input bit ifw, input bit fl, input logic [31:0] tgt_raw,
                              input bit mv, input logic [31:0] md,
                              output bit req, output logic [31:0] addr);
        logic [31:0] tgt;
        tgt  = {tgt_raw[31:2], 2'b00};
        req  = 1'b0;
        addr = 32'h0;
        if (skid_q.size() > 0) begin
            if (fl) begin
                skid_q.delete();
                m_pc = tgt;
                model_bubble();
            end else if (ifw) begin
                m_val_ifid = 1'b1;
                m_pc_ifid  = skid_q[0].pc;
                m_ins_ifid = skid_q[0].ins;
                skid_q.delete();
                if (pcw) m_pc = m_pc + 32'd4;
                model_issue(m_pc, req, addr);
            end
        end else if (pend_q.size() == 0) begin
            if (fl) m_pc = tgt;
            else    model_issue(m_pc, req, addr);
            if (fl || ifw) model_bubble();
        end else if (!pend_q[0].live) begin
            if (mv) pend_q.delete();
            if (fl) m_pc = tgt;
            if (fl || ifw) model_bubble();
        end else if (fl) begin
            model_bubble();
            m_pc = tgt;
            if (mv) begin
                pend_q.delete();
                model_issue(tgt, req, addr);
            end else begin
                pend_q[0] = '{pend_q[0].addr, 1'b0};
            end
        end else if (mv && ifw) begin
            m_val_ifid = 1'b1;
            m_pc_ifid  = pend_q[0].addr;
            m_ins_ifid = md;
            pend_q.delete();
            if (pcw) begin
                m_pc = m_pc + 32'd4;
                model_issue(m_pc, req, addr);
            end
        end else if (mv) begin
            skid_q.push_back('{pend_q[0].addr, md});
            pend_q.delete();
        end else if (ifw) begin
            model_bubble();
        end
    endtask

    // One cycle with the bench acting as a memory of the given latency; entered and left at posedge+1.
    task automatic sim_cycle(input bit pcw, input bit ifw, input bit fl, input logic [31:0] tgt,
                             input int lat);
        bit          mv, e_req;
        logic [31:0] md, e_addr;
        mv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        md = mv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        if (mv) void'(mem_q.pop_front());
        PCWrite = pcw;  IFIDWrite = ifw;  Flush = fl;  pc_target = tgt;
        imem_valid = mv;  imem_rdata = md;
        @(negedge clk);
        chk($sformatf("c%0d_valid", cyc), 32'(IFID_Valid), 32'(m_val_ifid));
        if (m_val_ifid) begin
            chk($sformatf("c%0d_pc", cyc), IFID_PC, m_pc_ifid);
            chk($sformatf("c%0d_pc4", cyc), IFID_PC4, m_pc_ifid + 32'd4);
        end
        chk($sformatf("c%0d_instr", cyc), IFID_Instr, m_ins_ifid);
        chk($sformatf("c%0d_busy", cyc), 32'(fetch_busy), 32'(pend_q.size() > 0));
        model_step(pcw, ifw, fl, tgt, mv, md, e_req, e_addr);
        chk($sformatf("c%0d_req", cyc), 32'(imem_req), 32'(e_req));
        if (e_req) chk($sformatf("c%0d_addr", cyc), imem_addr, e_addr);
        if (imem_req) begin
            mem_q.push_back('{cyc + lat, imem_addr});
            n_req++;
            last_req_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;  PCWrite = 1'b0;  IFIDWrite = 1'b0;  Flush = 1'b0;
        imem_valid = 1'b0;  pc_target = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
        n_req = 0;
        last_req_addr = 32'hFFFF_FFFF;
    endtask

    initial begin
        vec_t        v;
        bit          pcw, ifw, fl;
        logic [31:0] tgt;

        rst_n = 1'b0;  PCWrite = 1'b1;  IFIDWrite = 1'b1;  Flush = 1'b0;
        pc_target = 32'h0;  imem_valid = 1'b0;  imem_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_pc", IFID_PC, 32'h0);
        chk("reset_pc4", IFID_PC4, 32'h4);
        chk("reset_valid", 32'(IFID_Valid), 32'h0);
        chk("reset_instr", IFID_Instr, NOP);
        chk("reset_req", 32'(imem_req), 32'h0);
        chk("reset_busy", 32'(fetch_busy), 32'h0);
        @(posedge clk);
        #1;

        // rst pcw ifw fl tgt mv md | req addr | val pc instr | busy
        tbl.push_back(row(0,1,1,0,0, 0,0,                      0,0,            0,0,0,                        0));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      1,0,            0,0,0,                        0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(0),            1,4,            0,0,0,                        1));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(4),            1,8,            1,0,mem_word(0),              1));
        tbl.push_back(row(1,0,0,0,0, 1,mem_word(8),            0,0,            1,4,mem_word(4),              1));
        tbl.push_back(row(1,0,0,0,0, 0,0,                      0,0,            1,4,mem_word(4),              0));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      1,'hC,          1,4,mem_word(4),              0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word('hC),          1,'h10,         1,8,mem_word(8),              1));
        tbl.push_back(row(1,0,0,1,'h40, 1,mem_word('h10),      1,'h40,         1,'hC,mem_word('hC),          1));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word('h40),         1,'h44,         0,0,0,                        1));
        tbl.push_back(row(1,1,1,1,'h103, 0,0,                  0,0,            1,'h40,mem_word('h40),        1));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      0,0,            0,0,0,                        1));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word('h44),         0,0,            0,0,0,                        1));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      1,'h100,        0,0,0,                        0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word('h100),        1,'h104,        0,0,0,                        1));
        tbl.push_back(row(1,1,1,1,'hFFFF_FFFC, 1,mem_word('h104), 1,'hFFFF_FFFC, 1,'h100,mem_word('h100),    1));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word('hFFFF_FFFC),  1,0,            0,0,0,                        1));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(0),            1,4,            1,'hFFFF_FFFC,mem_word('hFFFF_FFFC), 1));
        tbl.push_back(row(1,0,1,0,0, 1,mem_word(4),            0,0,            1,0,mem_word(0),              1));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      1,4,            1,4,mem_word(4),              0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(4),            1,8,            0,0,0,                        1));
        tbl.push_back(row(0,1,1,0,0, 0,0,                      0,0,            1,4,mem_word(4),              1));
        tbl.push_back(row(0,1,1,0,0, 0,0,                      0,0,            0,0,0,                        0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(8),            1,0,            0,0,0,                        0));
        tbl.push_back(row(1,1,1,0,0, 1,mem_word(0),            1,4,            0,0,0,                        1));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      0,0,            1,0,mem_word(0),              1));
        tbl.push_back(row(1,1,1,0,0, 0,0,                      0,0,            0,0,0,                        1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst_n = v.rst;  PCWrite = v.pcw;  IFIDWrite = v.ifw;  Flush = v.fl;
            pc_target = v.tgt;  imem_valid = v.mv;  imem_rdata = v.md;
            @(negedge clk);
            chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(v.e_req));
            if (v.e_req) chk($sformatf("row%0d_addr", i), imem_addr, v.e_addr);
            chk($sformatf("row%0d_valid", i), 32'(IFID_Valid), 32'(v.e_val));
            if (v.e_val) begin
                chk($sformatf("row%0d_pc", i), IFID_PC, v.e_pc);
                chk($sformatf("row%0d_pc4", i), IFID_PC4, v.e_pc + 32'd4);
                chk($sformatf("row%0d_instr", i), IFID_Instr, v.e_ins);
            end else begin
                chk($sformatf("row%0d_nop", i), IFID_Instr, NOP);
            end
            chk($sformatf("row%0d_busy", i), 32'(fetch_busy), 32'(v.e_busy));
            @(posedge clk);
            #1;
        end

        // Latency-3 memory: one request per three cycles, then a flush while 0x0C is outstanding.
        do_reset();
        for (int i = 0; i < 9; i++) sim_cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        chk("lat3_req_count", 32'(n_req), 32'd3);
        sim_cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        chk("lat3_req_0c", last_req_addr, 32'h0000_000C);
        sim_cycle(1'b1, 1'b1, 1'b1, 32'h100, 3);
        for (int i = 0; i < 5; i++) sim_cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        chk("flush_next_addr", last_req_addr, 32'h0000_0100);
        chk("flush_req_count", 32'(n_req), 32'd5);

        // Random hazard-unit traffic against the model with latency 1..4.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ifw = ($urandom_range(0, 99) < 75);
            pcw = ($urandom_range(0, 99) < 85) ? ifw : 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 99) < 7);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            sim_cycle(pcw, ifw, fl, tgt, int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
